// File: rtl/alu9_driver_if.sv
// Bus bundle for alu9_driver: request handshake, ALU operand/result bus, response handshake.
// slave is the driver's view; master is the view of whatever surrounds it (issue logic + ALU).
interface alu9_driver_if;
    // Request side
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic        req_use_acc;

    // Combinational ALU side
    logic [31:0] alu_input1;
    logic [31:0] alu_input2;
    logic [4:0]  alu_shiftValue;
    logic [3:0]  alu_ALUSel;
    logic [31:0] alu_result;
    logic        alu_carryFlag;
    logic        alu_zeroFlag;
    logic        alu_overFlowFlag;
    logic        alu_signFlag;

    // Response side
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_illegal;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_shamt, req_use_acc,
        output req_ready,
        output alu_input1, alu_input2, alu_shiftValue, alu_ALUSel,
        input  alu_result, alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag,
        output rsp_valid, rsp_result, rsp_flags, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_shamt, req_use_acc,
        input  req_ready,
        input  alu_input1, alu_input2, alu_shiftValue, alu_ALUSel,
        output alu_result, alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag,
        input  rsp_valid, rsp_result, rsp_flags, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/alu9_driver.sv
// alu9_driver: request FIFO -> registered ALU operands -> captured response, with an
// accumulator for chained operations. Optional statistics counters are enabled by
// defining ALU_DRV_STATS_EN (adds op_count_o / ovf_count_o).
module alu9_driver #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu9_driver_if.slave        bus,
    output logic                busy_o
`ifdef ALU_DRV_STATS_EN
    ,
    output logic [15:0]         op_count_o,
    output logic [15:0]         ovf_count_o
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic        use_acc;
    } req_t;

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    state_e          state_q, state_d;
    req_t            mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop, capture, rsp_clear, fifo_empty;
    req_t            head, entry_in;

    logic [31:0]     alu_in1_q, alu_in2_q, acc_q, rsp_result_q;
    logic [4:0]      alu_shamt_q;
    logic [3:0]      alu_sel_q, rsp_flags_q;
    logic            rsp_valid_q, rsp_illegal_q;

    assign fifo_empty    = (count_q == '0);
    assign bus.req_ready = (count_q != CntW'(FIFO_DEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign head          = mem_q[rd_ptr_q];
    assign entry_in      = '{op: bus.req_op, a: bus.req_a, b: bus.req_b,
                             shamt: bus.req_shamt, use_acc: bus.req_use_acc};

    // FIFO storage; contents need no reset because count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Occupancy next-state; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        capture   = 1'b0;
        rsp_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_clear = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StDrive;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ALU operand registers, loaded on every pop and otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_shamt_q <= '0;
            alu_sel_q   <= '0;
        end else if (pop) begin
            alu_in1_q   <= head.use_acc ? acc_q : head.a;
            alu_in2_q   <= head.b;
            alu_shamt_q <= head.shamt;
            alu_sel_q   <= head.op;
        end
    end

    // Response and accumulator capture at the end of DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_illegal_q <= 1'b0;
            acc_q         <= '0;
        end else if (capture) begin
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= bus.alu_result;
            rsp_flags_q   <= {bus.alu_carryFlag, bus.alu_overFlowFlag,
                              bus.alu_signFlag, bus.alu_zeroFlag};
            rsp_illegal_q <= alu_sel_q[3];
            acc_q         <= bus.alu_result;
        end else if (rsp_clear) begin
            rsp_valid_q   <= 1'b0;
        end
    end

`ifdef ALU_DRV_STATS_EN
    logic [15:0] op_count_q, ovf_count_q;

    // Capture statistics: op count wraps, overflow count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q  <= '0;
            ovf_count_q <= '0;
        end else if (capture) begin
            op_count_q <= op_count_q + 16'd1;
            if (bus.alu_overFlowFlag && (ovf_count_q != 16'hFFFF)) begin
                ovf_count_q <= ovf_count_q + 16'd1;
            end
        end
    end

    assign op_count_o  = op_count_q;
    assign ovf_count_o = ovf_count_q;
`endif

    assign bus.alu_input1     = alu_in1_q;
    assign bus.alu_input2     = alu_in2_q;
    assign bus.alu_shiftValue = alu_shamt_q;
    assign bus.alu_ALUSel     = alu_sel_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_result     = rsp_result_q;
    assign bus.rsp_flags      = rsp_flags_q;
    assign bus.rsp_illegal    = rsp_illegal_q;
    assign busy_o             = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu9_driver.sv
// Self-checking bench for alu9_driver: directed cases plus randomized traffic scored
// against an in-order reference model of request -> response behaviour.
module tb_alu9_driver;

    logic clk;
    logic rst_n;
    logic busy;
`ifdef ALU_DRV_STATS_EN
    logic [15:0] op_count, ovf_count;
`endif

    alu9_driver_if bus ();

    alu9_driver #(.FIFO_DEPTH(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
`ifdef ALU_DRV_STATS_EN
        ,
        .op_count_o  (op_count),
        .ovf_count_o (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour: returns {carry, ovf, sign, zero, result[31:0]}.
    function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s, d;
        logic [31:0] r;
        logic        c, v;
        s = {1'b0, a} + {1'b0, b};
        d = {1'b0, a} + {1'b0, ~b} + 33'd1;
        c = d[32];
        v = (a[31] != b[31]) && (d[31] != a[31]);
        case (op)
            4'd0: begin r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (s[31] != a[31]); end
            4'd1: r = d[31:0];
            4'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: r = (a < b) ? 32'd1 : 32'd0;
            4'd4: r = (a == b) ? 32'd1 : 32'd0;
            4'd5: r = (a != b) ? 32'd1 : 32'd0;
            4'd6: r = ($signed(a) > $signed(b)) ? a : b;
            4'd7: r = ($signed(a) < $signed(b)) ? a : b;
            default: begin r = 32'd0; c = 1'b0; v = 1'b0; end
        endcase
        return {c, v, r[31], (r == 32'd0), r};
    endfunction

    logic [35:0] alu_out;
    assign alu_out              = alu_ref(bus.alu_ALUSel, bus.alu_input1, bus.alu_input2);
    assign bus.alu_result       = alu_out[31:0];
    assign bus.alu_zeroFlag     = alu_out[32];
    assign bus.alu_signFlag     = alu_out[33];
    assign bus.alu_overFlowFlag = alu_out[34];
    assign bus.alu_carryFlag    = alu_out[35];

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        illegal;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  shamt;
        logic [3:0]  sel;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          hs_cyc[$];
    logic [31:0] model_acc;
    int          n_checks, n_pass, cyc, n_hs, n_ovf;
    logic [31:0] last_result;
    logic [3:0]  last_flags;
    logic        last_illegal;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: requests complete in order, so the accumulator is simply the
    // result of the previously accepted request.
    task automatic model_accept();
        exp_t        x;
        logic [31:0] a_eff;
        logic [35:0] r;
        a_eff     = bus.req_use_acc ? model_acc : bus.req_a;
        r         = alu_ref(bus.req_op, a_eff, bus.req_b);
        model_acc = r[31:0];
        x.result  = r[31:0];
        x.flags   = {r[35], r[34], r[33], r[32]};
        x.illegal = (bus.req_op >= 4'd8);
        x.in1     = a_eff;
        x.in2     = bus.req_b;
        x.shamt   = bus.req_shamt;
        x.sel     = bus.req_op;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: score each response handshake, then record each request acceptance.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("rsp_spurious", bus.rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_result", bus.rsp_result, e.result);
                check("rsp_flags", bus.rsp_flags, e.flags);
                check("rsp_illegal", bus.rsp_illegal, e.illegal);
                check("alu_input1", bus.alu_input1, e.in1);
                check("alu_input2", bus.alu_input2, e.in2);
                check("alu_shift", bus.alu_shiftValue, e.shamt);
                check("alu_sel", bus.alu_ALUSel, e.sel);
            end
            last_result  = bus.rsp_result;
            last_flags   = bus.rsp_flags;
            last_illegal = bus.rsp_illegal;
            n_hs++;
            if (bus.rsp_flags[2]) n_ovf++;
        end
        if (rst_n && bus.req_valid && bus.req_ready) model_accept();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] shamt, input logic use_acc);
        int n;
        bus.req_op      = op;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_shamt   = shamt;
        bus.req_use_acc = use_acc;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            step();
            n++;
        end
        if (!bus.req_ready) check("send_timeout", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            step();
            n++;
        end
        check("idle_busy", busy, 1'b0);
        check("idle_pending", exp_q.size(), 0);
    endtask

    task automatic tb_reset_state();
        exp_q.delete();
        model_acc = '0;
        n_hs      = 0;
        n_ovf     = 0;
    endtask

    bit rand_done;

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        tb_reset_state();
        last_result = '0; last_flags = '0; last_illegal = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_shamt = '0; bus.req_use_acc = 1'b0; bus.rsp_ready = 1'b1;

        // Reset state
        #3;
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_flags", bus.rsp_flags, 4'd0);
        check("rst_rsp_illegal", bus.rsp_illegal, 1'b0);
        check("rst_alu_in", {bus.alu_input1, bus.alu_input2}, 64'd0);
        check("rst_alu_sel", {bus.alu_shiftValue, bus.alu_ALUSel}, 9'd0);
        step(); step();
        rst_n = 1'b1;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);

        // ADD overflow with latency check
        send(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b0);
        check("lat_n0_valid", bus.rsp_valid, 1'b0);
        step();
        check("lat_n1_valid", bus.rsp_valid, 1'b0);
        check("lat_n1_in1", bus.alu_input1, 32'h7FFF_FFFF);
        check("lat_n1_shamt", bus.alu_shiftValue, 5'd3);
        step();
        check("lat_n2_valid", bus.rsp_valid, 1'b1);
        check("add_ovf_result", bus.rsp_result, 32'h8000_0000);
        check("add_ovf_flags", bus.rsp_flags, 4'b0110);
        wait_idle();

        // SUB equal, then SLT signed
        send(4'd1, 32'd5, 32'd5, 5'd0, 1'b0);
        wait_idle();
        check("sub_result", last_result, 32'd0);
        check("sub_flags", last_flags, 4'b1001);
        send(4'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        wait_idle();
        check("slt_result", last_result, 32'd1);

        // Accumulator chain
        send(4'd0, 32'd10, 32'd20, 5'd0, 1'b0);
        wait_idle();
        send(4'd0, 32'h0000_DEAD, 32'd12, 5'd0, 1'b1);
        wait_idle();
        check("acc_chain", last_result, 32'd42);

        // Backpressure with a full FIFO
        bus.rsp_ready = 1'b0;
        send(4'd0, 32'd1, 32'd2, 5'd1, 1'b0);
        send(4'd1, 32'd9, 32'd4, 5'd2, 1'b0);
        send(4'd4, 32'd6, 32'd6, 5'd4, 1'b0);
        check("bp_req_ready", bus.req_ready, 1'b0);
        repeat (4) step();
        check("bp_hold_valid", bus.rsp_valid, 1'b1);
        check("bp_hold_result", bus.rsp_result, 32'd3);
        check("bp_hold_in1", bus.alu_input1, 32'd1);
        hs_cyc.delete();
        bus.rsp_ready = 1'b1;
        wait_idle();
        check("bp_count", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
            check("bp_gap1", hs_cyc[1] - hs_cyc[0], 2);
            check("bp_gap2", hs_cyc[2] - hs_cyc[1], 2);
        end
        check("bp_last", last_result, 32'd1);

        // Illegal op
        send(4'b1010, 32'd7, 32'd3, 5'd0, 1'b0);
        wait_idle();
        check("ill_result", last_result, 32'd0);
        check("ill_flag", last_illegal, 1'b1);
        check("ill_zero", last_flags[0], 1'b1);

        // Reset asserted during DRIVE
        send(4'd1, 32'd100, 32'd1, 5'd7, 1'b0);
        step();
        check("mid_pre_sel", bus.alu_ALUSel, 4'd1);
        rst_n = 1'b0;
        tb_reset_state();
        #1;
        check("mid_rsp_valid", bus.rsp_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_alu_sel", bus.alu_ALUSel, 4'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post_rst_no_rsp", bus.rsp_valid, 1'b0);
        end
        check("post_rst_ready", bus.req_ready, 1'b1);

        // Randomized traffic with random response backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send(4'($urandom_range(0, 15)), $urandom, $urandom,
                         5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                    step();
                end
                bus.rsp_ready = 1'b1;
            end
        join
        wait_idle();

`ifdef ALU_DRV_STATS_EN
        check("stat_op_count", op_count, 16'(n_hs));
        check("stat_ovf_count", ovf_count, 16'(n_ovf));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu9_driver.md
# alu9_driver

Sequential front end for the 32-bit comparison/arithmetic ALU (alu9). It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. It drives registered operands and the select onto the combinational ALU, then captures the result and the four flags into a response register that has its own valid/ready handshake. It sits between the issue logic and the ALU datapath, and it supports chained operations through an internal accumulator.

## Interface
- FIFO_DEPTH, 2, request FIFO entries; power of two, minimum 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request FIFO not full; depends only on FIFO state.
- req_op  in  4  ALU select: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 EQ, 5 NEQ, 6 MAX, 7 MIN.
- req_a, req_b  in  32  operands.
- req_shamt  in  5  shift amount, passed through to the ALU.
- req_use_acc  in  1  substitute the accumulator for req_a.
- alu_input1, alu_input2  out  32  registered operands to the ALU.
- alu_shiftValue  out  5  registered shift amount.
- alu_ALUSel  out  4  registered select.
- alu_result  in  32  ALU result.
- alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag  in  1  ALU flags.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_result  out  32  captured result.
- rsp_flags  out  4  captured flags as {carry, overflow, sign, zero}.
- rsp_illegal  out  1  the captured op was 8–15.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- **FSM states:** IDLE, DRIVE, RESP.
- **IDLE:**
  - If the FIFO is non-empty: pop the head, load the alu_* registers, go to DRIVE.
  - Operand A is acc when use_acc=1, otherwise req_a.
- **DRIVE:** lasts exactly one cycle, so the ALU settles combinationally. At the closing edge:
  - capture alu_result into rsp_result and into acc;
  - capture the flags into rsp_flags;
  - set rsp_illegal = (op ≥ 8);
  - set rsp_valid=1; go to RESP.
- **RESP:** hold all rsp_* and alu_* values stable while rsp_ready=0.
  - On rsp_valid && rsp_ready with the FIFO non-empty: clear rsp_valid, pop the next request, load alu_*, go to DRIVE (back-to-back).
  - On the handshake with the FIFO empty: clear rsp_valid, go to IDLE.
- **FIFO:**
  - A push occurs on req_valid && req_ready.
  - Simultaneous push and pop are legal and leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push while full cannot occur, because req_ready=0 when full.
- **Accumulator:**
  - 32-bit, updated only on capture, holding the previous result unmodified (e.g., an SLT result of 0/1 is stored as is).
  - use_acc reads the acc value at pop time, which always reflects the last completed operation.
- **Illegal ops (8–15):**
  - Forwarded to the ALU unchanged; the ALU returns 0.
  - The flags are captured as presented; rsp_illegal=1.
- **Arithmetic:** none is performed in this block. Widths pass through unchanged.

## Timing
- **Latency:** a request accepted at edge N into an empty FIFO with the FSM in IDLE:
  - pops at edge N+1;
  - alu_* valid after N+1;
  - rsp_valid high after N+2.
- **Throughput:** one operation per 2 cycles with rsp_ready held high.
- **Reset (asynchronous, active-low):**
  - FSM to IDLE; FIFO empty.
  - rsp_valid, rsp_result, rsp_flags, rsp_illegal all 0.
  - acc 0.
  - alu_input1, alu_input2, alu_shiftValue 0; alu_ALUSel 0 (ADD).
  - req_ready 1 after release; busy 0.
- **Reset mid-operation:** any in-flight or buffered request is discarded. No response is emitted after release.
- **Post-reset:** the first edge with rst_n=1 is a normal cycle.

## Configuration
- **ALU_DRV_STATS_EN defined:**
  - Adds outputs op_count[15:0] and ovf_count[15:0], both reset to 0.
  - op_count increments on every capture and wraps from 0xFFFF to 0.
  - ovf_count increments on a capture with overflow=1 and saturates at 0xFFFF.
- **ALU_DRV_STATS_EN undefined:** the ports and counters are absent. All other behaviour is identical.

## Test plan
- ADD a=0x7FFFFFFF, b=1, rsp_ready=1 -> rsp_result=0x80000000, flags carry=0/ovf=1/sign=1/zero=0, rsp_valid exactly 2 cycles after acceptance.
- SUB a=5, b=5 -> rsp_result=0, zero=1, carry=1, ovf=0; followed by SLT a=0xFFFFFFFF, b=1 -> rsp_result=1.
- ADD 10+20, then ADD with use_acc=1, req_a=0xDEAD, b=12 -> second rsp_result=42 (0x2A).
- rsp_ready=0, FIFO_DEPTH=2, push 3 requests -> first enters DRIVE; req_ready drops after the third push; rsp_result holds the first result. Release rsp_ready -> three responses in order, 2 cycles apart.
- req_op=4'b1010, a=7, b=3 -> rsp_result=0, rsp_illegal=1, zero=1.
- Assert rst_n low during DRIVE -> rsp_valid and busy 0 immediately, alu_ALUSel=0; after release no response appears and req_ready=1.
